// File: rtl/dw_block_sched.sv
// rtl/dw_block_sched.sv - depthwise block scheduler: walks POYxPOX output tiles per channel
// Optional build macro: DW_SCHED_PERF_EN (busy/stall performance counters).
module dw_block_sched #(
  parameter int POY    = 3,
  parameter int POX    = 16,
  parameter int KSIZE  = 3,
  parameter int STRIDE = 1,
  parameter int HW     = 8,
  parameter int CW     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [HW-1:0]              cfg_fm_h,
  input  logic [HW-1:0]              cfg_fm_w,
  input  logic [CW-1:0]              cfg_ch,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic [HW-1:0]              blk_row,
  output logic [HW-1:0]              blk_col,
  output logic [CW-1:0]              blk_ch,
  output logic [$clog2(POY+1)-1:0]   blk_yvalid,
  output logic [$clog2(POX+1)-1:0]   blk_xvalid,
  input  logic                       stall,
  output logic                       blkend,
  output logic [31:0]                perf_busy_cyc,
  output logic [31:0]                perf_stall_cyc
);

  localparam int YW = $clog2(POY+1);
  localparam int XW = $clog2(POX+1);
  localparam int L  = (POY-1)*STRIDE + KSIZE;
  localparam int BW = $clog2(L+1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    state, state_nx;
  logic [HW-1:0] fm_h, fm_w, oh, ow, row, col;
  logic [CW-1:0] ch_num, ch;
  logic [BW-1:0] beat;
  logic [HW-1:0] yrem, xrem;
  logic [HW:0]   col_end, row_end;
  logic          cfg_take, cfg_bad, hshake, beat_last, col_wrap, row_wrap, last_tile;

  assign cfg_take  = (state == S_IDLE) && cfg_valid;
  assign cfg_bad   = (cfg_fm_h < HW'(KSIZE)) || (cfg_fm_w < HW'(KSIZE)) || (cfg_ch == '0);
  assign hshake    = (state == S_ISSUE) && blk_ready && !abort;
  assign beat_last = (state == S_STREAM) && (beat == BW'(L-1)) && !stall;

  // Tile-edge tests are done one bit wider so a tile near 2^HW cannot wrap around.
  assign col_end   = {1'b0, col} + (HW+1)'(POX);
  assign row_end   = {1'b0, row} + (HW+1)'(POY);
  assign col_wrap  = col_end >= {1'b0, ow};
  assign row_wrap  = row_end >= {1'b0, oh};
  assign last_tile = col_wrap && row_wrap && (ch == ch_num - CW'(1));

  assign yrem       = oh - row;
  assign xrem       = ow - col;
  assign blk_yvalid = (yrem < HW'(POY)) ? yrem[YW-1:0] : YW'(POY);
  assign blk_xvalid = (xrem < HW'(POX)) ? xrem[XW-1:0] : XW'(POX);
  assign blk_row    = row;
  assign blk_col    = col;
  assign blk_ch     = ch;

  assign cfg_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign blk_valid = (state == S_ISSUE);
  assign blkend    = beat_last && !abort;
  assign done      = (state == S_DONE) && !abort;

  // Next-state selection; abort from any active state returns to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (cfg_valid && !cfg_bad) state_nx = S_LOAD;
      S_LOAD:   state_nx = S_ISSUE;
      S_ISSUE:  if (blk_ready) state_nx = S_STREAM;
      S_STREAM: if (beat_last) state_nx = S_NEXT;
      S_NEXT:   state_nx = last_tile ? S_DONE : S_ISSUE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nx = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Config latch, output-size computation, tile walk and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fm_h    <= '0;
      fm_w    <= '0;
      ch_num  <= '0;
      oh      <= '0;
      ow      <= '0;
      row     <= '0;
      col     <= '0;
      ch      <= '0;
      beat    <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_take && cfg_bad;
      if (cfg_take) begin
        fm_h   <= cfg_fm_h;
        fm_w   <= cfg_fm_w;
        ch_num <= cfg_ch;
      end
      if (!abort) begin
        case (state)
          S_LOAD: begin
            oh  <= ((fm_h - HW'(KSIZE)) >> (STRIDE-1)) + HW'(1);
            ow  <= ((fm_w - HW'(KSIZE)) >> (STRIDE-1)) + HW'(1);
            row <= '0;
            col <= '0;
            ch  <= '0;
          end
          S_ISSUE:  if (hshake) beat <= '0;
          S_STREAM: if (!stall) beat <= beat + BW'(1);
          S_NEXT: begin
            if (col_wrap) begin
              col <= '0;
              if (row_wrap) begin
                row <= '0;
                ch  <= ch + CW'(1);
              end else begin
                row <= row + HW'(POY);
              end
            end else begin
              col <= col + HW'(POX);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DW_SCHED_PERF_EN
  logic [31:0] busy_cyc, stall_cyc;

  // Saturating busy/stall cycle counters, cleared when a layer is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cyc  <= '0;
      stall_cyc <= '0;
    end else if (cfg_take && !cfg_bad) begin
      busy_cyc  <= '0;
      stall_cyc <= '0;
    end else begin
      if (busy && (busy_cyc != '1)) busy_cyc <= busy_cyc + 32'd1;
      if ((state == S_STREAM) && stall && (stall_cyc != '1)) stall_cyc <= stall_cyc + 32'd1;
    end
  end

  assign perf_busy_cyc  = busy_cyc;
  assign perf_stall_cyc = stall_cyc;
`else
  assign perf_busy_cyc  = 32'd0;
  assign perf_stall_cyc = 32'd0;
`endif

endmodule

// File: tb/tb_dw_block_sched.sv
// tb/tb_dw_block_sched.sv - self-checking bench for dw_block_sched against a tile-list model
module tb_dw_block_sched;
  localparam int POY = 3, POX = 16, KSIZE = 3, STRIDE = 1, HW = 8, CW = 10;
  localparam int L = (POY-1)*STRIDE + KSIZE;

  logic clk = 1'b0;
  logic rst;
  logic cfg_valid, cfg_ready, abort, busy, done, cfg_err, blk_valid, blk_ready, stall, blkend;
  logic [HW-1:0] cfg_fm_h, cfg_fm_w, blk_row, blk_col;
  logic [CW-1:0] cfg_ch, blk_ch;
  logic [1:0]  blk_yvalid;
  logic [4:0]  blk_xvalid;
  logic [31:0] perf_busy_cyc, perf_stall_cyc;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {int row; int col; int ch; int yv; int xv;} desc_t;
  desc_t exp_q[$];

  always #5 clk = ~clk;

  dw_block_sched #(.POY(POY), .POX(POX), .KSIZE(KSIZE), .STRIDE(STRIDE), .HW(HW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_fm_h(cfg_fm_h), .cfg_fm_w(cfg_fm_w), .cfg_ch(cfg_ch), .abort(abort),
    .busy(busy), .done(done), .cfg_err(cfg_err), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_row(blk_row), .blk_col(blk_col), .blk_ch(blk_ch), .blk_yvalid(blk_yvalid),
    .blk_xvalid(blk_xvalid), .stall(stall), .blkend(blkend),
    .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected tile list: channel outer, rows, then columns; extents clipped to the map edge.
  task automatic build(input int h, input int w, input int c);
    int oh, ow;
    desc_t d;
    oh = (h - KSIZE) / STRIDE + 1;
    ow = (w - KSIZE) / STRIDE + 1;
    exp_q.delete();
    for (int k = 0; k < c; k++)
      for (int r = 0; r < oh; r += POY)
        for (int x = 0; x < ow; x += POX) begin
          d.row = r; d.col = x; d.ch = k;
          d.yv = (oh - r < POY) ? oh - r : POY;
          d.xv = (ow - x < POX) ? ow - x : POX;
          exp_q.push_back(d);
        end
  endtask

  task automatic offer(input int h, input int w, input int c);
    cfg_fm_h = HW'(h); cfg_fm_w = HW'(w); cfg_ch = CW'(c); cfg_valid = 1'b1;
    #1;
    chk("cfg_ready_offer", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  // Runs one layer; abort_at>0 aborts while block number abort_at is being offered.
  task automatic run_layer(input int h, input int w, input int c,
                           input int stall_pct, input int ready_pct, input int abort_at);
    int since_end, beats, n_hs, cyc;
    bit pend, in_stream, exp_done, exp_end, finished;
    desc_t d;
    build(h, w, c);
    offer(h, w, c);
    chk("load_blk_valid", blk_valid, 0);
    chk("load_busy", busy, 1);
    chk("load_cfg_ready", cfg_ready, 0);
    since_end = 1; beats = 0; n_hs = 0; pend = 0; in_stream = 0; finished = 0;
    stall = 1'b0; blk_ready = 1'b0;
    for (cyc = 0; cyc < 20000 && !finished; cyc++) begin
      tick();
      if (since_end >= 0) since_end++;
      if (since_end == 2 && exp_q.size() > 0) pend = 1;
      exp_done = (since_end == 2) && (exp_q.size() == 0);
      stall = ($urandom_range(99) < stall_pct);
      blk_ready = ($urandom_range(99) < ready_pct);
      abort = 1'b0;
      if (abort_at > 0 && pend && n_hs == abort_at - 1) begin
        abort = 1'b1;
        blk_ready = 1'b1;
      end
      #1;
      exp_end = in_stream && (beats == L-1) && !stall;
      chk("blk_valid", blk_valid, pend);
      chk("done", done, exp_done);
      chk("blkend", blkend, exp_end);
      if (abort) begin
        tick();
        abort = 1'b0; blk_ready = 1'b0;
        #1;
        chk("abort_idle", cfg_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_blk_valid", blk_valid, 0);
        chk("abort_done", done, 0);
        tick();
        chk("abort_no_done", done, 0);
        return;
      end
      if (exp_done) begin
        finished = 1;
      end else begin
        if (in_stream && !stall) beats++;
        if (exp_end) begin
          in_stream = 0;
          since_end = 0;
        end
        if (pend && blk_ready) begin
          d = exp_q.pop_front();
          chk("desc_row", blk_row, d.row);
          chk("desc_col", blk_col, d.col);
          chk("desc_ch", blk_ch, d.ch);
          chk("desc_yvalid", blk_yvalid, d.yv);
          chk("desc_xvalid", blk_xvalid, d.xv);
          pend = 0; in_stream = 1; beats = 0; since_end = -1; n_hs++;
        end
      end
    end
    chk("layer_finished", finished, 1);
    stall = 1'b0; blk_ready = 1'b0;
    tick();
    chk("post_done_ready", cfg_ready, 1);
    chk("post_done_busy", busy, 0);
    chk("post_done_pulse", done, 0);
  endtask

  initial begin
    int end_k;
    rst = 1'b1; cfg_valid = 1'b0; cfg_fm_h = '0; cfg_fm_w = '0; cfg_ch = '0;
    abort = 1'b0; blk_ready = 1'b0; stall = 1'b0;
    repeat (2) tick();
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_blkend", blkend, 0);
    chk("rst_blk_row", blk_row, 0);
    chk("rst_blk_col", blk_col, 0);
    chk("rst_blk_ch", blk_ch, 0);
    chk("rst_yvalid", blk_yvalid, 0);
    chk("rst_xvalid", blk_xvalid, 0);
    chk("rst_perf_busy", perf_busy_cyc, 0);
    chk("rst_perf_stall", perf_stall_cyc, 0);
    rst = 1'b0;
    tick();

    // Plan layers: 18x18x2 and 20x34x1, router always ready, no stall.
    run_layer(18, 18, 2, 0, 100, 0);
    run_layer(20, 34, 1, 0, 100, 0);

    // Rejected configurations, including the width-2 case.
    offer(18, 2, 1);
    chk("err_w_pulse", cfg_err, 1);
    chk("err_w_ready", cfg_ready, 1);
    chk("err_w_valid", blk_valid, 0);
    tick();
    chk("err_w_pulse_end", cfg_err, 0);
    chk("err_w_valid2", blk_valid, 0);
    chk("err_w_busy", busy, 0);
    offer(2, 18, 1);
    chk("err_h_pulse", cfg_err, 1);
    offer(18, 18, 0);
    chk("err_ch_pulse", cfg_err, 1);
    chk("err_ch_valid", blk_valid, 0);
    tick();

    // Smallest legal map (fm == KSIZE) gives a 1x1 output tile.
    run_layer(3, 3, 1, 0, 100, 0);

    // Four-cycle stall in the middle of a single-block layer.
    offer(5, 3, 1);
    blk_ready = 1'b1;
    tick();
    chk("stall_hs_valid", blk_valid, 1);
    chk("stall_hs_yvalid", blk_yvalid, 3);
    chk("stall_hs_xvalid", blk_xvalid, 1);
    end_k = -1;
    for (int k = 1; k <= 20 && end_k < 0; k++) begin
      tick();
      blk_ready = 1'b0;
      stall = (k >= 3 && k <= 6);
      #1;
      if (blkend === 1'b1) end_k = k;
    end
    stall = 1'b0;
    chk("stall_blkend_delay", end_k, L + 4);
    tick();
    chk("stall_next_done", done, 0);
    tick();
    chk("stall_done", done, 1);
    tick();

    // Abort while block 3 is offered, then a fresh layer restarts at origin.
    run_layer(18, 18, 1, 0, 100, 3);
    run_layer(20, 34, 1, 0, 100, 0);

    // Randomized layers with random stall and router back-pressure.
    for (int i = 0; i < 4; i++)
      run_layer($urandom_range(40, 3), $urandom_range(60, 3), $urandom_range(3, 1), 30, 60, 0);

    // Asynchronous reset during the stream of the second block (col 16).
    offer(20, 34, 1);
    blk_ready = 1'b1; stall = 1'b0;
    repeat (9) tick();
    chk("prerst_col", blk_col, 16);
    chk("prerst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cfg_ready", cfg_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_blk_valid", blk_valid, 0);
    chk("arst_blkend", blkend, 0);
    chk("arst_blk_col", blk_col, 0);
    chk("arst_done", done, 0);
    blk_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_layer(20, 34, 1, 20, 70, 0);

`ifndef DW_SCHED_PERF_EN
    chk("perf_busy_off", perf_busy_cyc, 0);
    chk("perf_stall_off", perf_stall_cyc, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
